voice_allocator: RTL

Polyphonic voice allocator that drives a bank of `NUM_VOICES` phase-accumulator oscillators. It accepts note-on/note-off events from the control path through a valid/ready handshake and assigns each note to a voice. For every voice it outputs a tuning word, a gate and a one-cycle phase-reset pulse, and it steals the least-recently-assigned voice when all voices are busy.

---
 rtl/synth_pkg.sv | 15 +
 rtl/voice_rank_tracker.sv | 53 +++++
 rtl/voice_allocator.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path.
// Holds the allocator FSM state encoding and the default note / tuning-word
// widths that the allocator shares with the phase-accumulator oscillators.
package synth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   localparam int NOTE_WIDTH_DEF = 7;
   localparam int TW_WIDTH_DEF   = 32;

endpackage

// File: rtl/voice_rank_tracker.sv
// Least-recently-assigned tracker for the voice allocator.
// Keeps one rank per voice (0 = most recently assigned, NUM_VOICES-1 = oldest);
// the ranks always form a permutation, starting from rank[i] = i.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   promote       move voice promote_idx to rank 0 this cycle
//   promote_idx   voice being (re)assigned
//   is_oldest     one-hot flag of the voice currently holding the oldest rank
module voice_rank_tracker
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int IDX_W      = $clog2(NUM_VOICES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  promote,
   input  logic [IDX_W-1:0]      promote_idx,
   output logic [NUM_VOICES-1:0] is_oldest
);

   localparam logic [IDX_W-1:0] OLDEST_RANK = IDX_W'(NUM_VOICES - 1);

   logic [IDX_W-1:0] rank_arr [NUM_VOICES];
   logic [IDX_W-1:0] target_rank;

   // Rank the target held before promotion: only voices younger than it age,
   // which keeps the set a permutation without any wrap.
   assign target_rank = rank_arr[promote_idx];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_VOICES; gi++) begin : g_rank
         logic [IDX_W-1:0] rank_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               rank_reg <= IDX_W'(gi);
            end else if (promote) begin
               if (promote_idx == IDX_W'(gi)) begin
                  rank_reg <= '0;
               end else if (rank_reg < target_rank) begin
                  rank_reg <= rank_reg + IDX_W'(1);
               end
            end
         end

         assign rank_arr[gi]  = rank_reg;
         assign is_oldest[gi] = (rank_reg == OLDEST_RANK);
      end
   endgenerate

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator.
// Accepts note-on/note-off events over a valid/ready handshake, scans all
// voices one per cycle, then commits the result in a single cycle: retrigger
// a voice already playing the note, else take the lowest free voice, else
// steal the least-recently-assigned one.
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   ev_valid/ev_ready            event handshake
//   ev_on, ev_note, ev_tw        event payload (tw ignored for note-off)
//   voice_tw                     per-voice tuning word, voice i at [i*TW_WIDTH +: TW_WIDTH]
//   voice_gate                   per-voice gate
//   voice_rst                    one-cycle phase-reset pulse per voice
//   steal                        one-cycle pulse when a gated voice was stolen
module voice_allocator
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int TW_WIDTH   = TW_WIDTH_DEF,
   parameter int NOTE_WIDTH = NOTE_WIDTH_DEF
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           ev_valid,
   output logic                           ev_ready,
   input  logic                           ev_on,
   input  logic [NOTE_WIDTH-1:0]          ev_note,
   input  logic [TW_WIDTH-1:0]            ev_tw,
   output logic [NUM_VOICES*TW_WIDTH-1:0] voice_tw,
   output logic [NUM_VOICES-1:0]          voice_gate,
   output logic [NUM_VOICES-1:0]          voice_rst,
   output logic                           steal
);

   localparam int               IDX_W    = $clog2(NUM_VOICES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   state_t                state_reg, state_next;
   logic [IDX_W-1:0]      idx_reg;
   logic                  ev_on_reg;
   logic [NOTE_WIDTH-1:0] ev_note_reg;
   logic [TW_WIDTH-1:0]   ev_tw_reg;
   logic                  match_found_reg, free_found_reg;
   logic [IDX_W-1:0]      match_idx_reg, free_idx_reg, oldest_idx_reg;
   logic                  steal_reg;

   logic [NOTE_WIDTH-1:0] note_arr [NUM_VOICES];
   logic [NUM_VOICES-1:0] is_oldest;
   logic                  scan_match, scan_free;
   logic                  commit_on, commit_off, do_steal;
   logic [IDX_W-1:0]      target_idx;

   assign ev_ready = (state_reg == ST_IDLE) && !rst;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (ev_valid && ev_ready) state_next = ST_SCAN;
         ST_SCAN:   if (idx_reg == LAST_IDX) state_next = ST_COMMIT;
         ST_COMMIT: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   assign scan_match = voice_gate[idx_reg] && (note_arr[idx_reg] == ev_note_reg);
   assign scan_free  = !voice_gate[idx_reg];

   assign commit_on  = (state_reg == ST_COMMIT) && ev_on_reg;
   assign commit_off = (state_reg == ST_COMMIT) && !ev_on_reg && match_found_reg;
   assign do_steal   = commit_on && !match_found_reg && !free_found_reg;

   always_comb begin
      target_idx = oldest_idx_reg;
      if (match_found_reg)     target_idx = match_idx_reg;
      else if (free_found_reg) target_idx = free_idx_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         idx_reg         <= '0;
         ev_on_reg       <= 1'b0;
         ev_note_reg     <= '0;
         ev_tw_reg       <= '0;
         match_found_reg <= 1'b0;
         free_found_reg  <= 1'b0;
         match_idx_reg   <= '0;
         free_idx_reg    <= '0;
         oldest_idx_reg  <= '0;
         steal_reg       <= 1'b0;
      end else begin
         state_reg <= state_next;
         steal_reg <= do_steal;
         case (state_reg)
            ST_IDLE: begin
               if (ev_valid && ev_ready) begin
                  ev_on_reg       <= ev_on;
                  ev_note_reg     <= ev_note;
                  ev_tw_reg       <= ev_tw;
                  idx_reg         <= '0;
                  match_found_reg <= 1'b0;
                  free_found_reg  <= 1'b0;
               end
            end
            ST_SCAN: begin
               idx_reg <= idx_reg + IDX_W'(1);
               // Keep the first hit of each kind so the lowest index wins.
               if (scan_match && !match_found_reg) begin
                  match_found_reg <= 1'b1;
                  match_idx_reg   <= idx_reg;
               end
               if (scan_free && !free_found_reg) begin
                  free_found_reg <= 1'b1;
                  free_idx_reg   <= idx_reg;
               end
               if (is_oldest[idx_reg]) oldest_idx_reg <= idx_reg;
            end
            default: ;
         endcase
      end
   end

   assign steal = steal_reg;

   voice_rank_tracker #(
      .NUM_VOICES (NUM_VOICES),
      .IDX_W      (IDX_W)
   ) u_rank (
      .clk         (clk),
      .rst         (rst),
      .promote     (commit_on),
      .promote_idx (target_idx),
      .is_oldest   (is_oldest)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
         logic [TW_WIDTH-1:0]   tw_reg;
         logic [NOTE_WIDTH-1:0] note_reg;
         logic                  gate_reg;
         logic                  vrst_reg;
         logic                  is_target;

         assign is_target = (target_idx == IDX_W'(gi));

         always_ff @(posedge clk) begin
            if (rst) begin
               tw_reg   <= '0;
               note_reg <= '0;
               gate_reg <= 1'b0;
               vrst_reg <= 1'b0;
            end else begin
               vrst_reg <= 1'b0;
               if (commit_on && is_target) begin
                  tw_reg   <= ev_tw_reg;
                  note_reg <= ev_note_reg;
                  gate_reg <= 1'b1;
                  vrst_reg <= 1'b1;
               end else if (commit_off && (match_idx_reg == IDX_W'(gi))) begin
                  // tw and note stay so the oscillator rings through release.
                  gate_reg <= 1'b0;
               end
            end
         end

         assign voice_tw[gi*TW_WIDTH +: TW_WIDTH] = tw_reg;
         assign voice_gate[gi]                    = gate_reg;
         assign voice_rst[gi]                     = vrst_reg;
         assign note_arr[gi]                      = note_reg;
      end
   endgenerate

endmodule
